spi_byte_seq: RTL and testbench

Byte sequencer placed directly upstream of the SPI master (spi_master_m). It buffers outgoing bytes in a TX FIFO and launches one SPI byte transfer per entry through the master's START/BUSY/DOUT/DIN interface. It captures each received byte into an RX FIFO. Both sides use valid/ready handshakes, so a host or DMA engine can stream bytes without tracking per-byte SPI timing.

---
 rtl/spi_seq_pkg.sv | 20 ++
 rtl/spi_fifo_m.sv | 74 +++++++
 rtl/spi_byte_seq.sv | 136 +++++++++++++
 tb/tb_spi_byte_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI byte sequencer and its FIFOs.
package spi_seq_pkg;

  // Width of one SPI transfer and of every FIFO entry.
  localparam int BYTE_W = 8;

  // Sequencer states: wait for work, pulse START, wait for BUSY to rise, wait for BUSY to fall.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  // Occupancy counters must represent 0..depth inclusive, hence one extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_m.sv
// Synchronous byte FIFO with registered storage, exact occupancy count and a
// head output that reads as zero while empty.
module spi_fifo_m
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [BYTE_W-1:0]           push_data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic [BYTE_W-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted when paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy; pointers wrap on their own since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Register FIFO state; reset empties the FIFO and clears storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/spi_byte_seq.sv
// Byte sequencer in front of the SPI master: drains a TX FIFO one byte per
// transfer and collects the received bytes into an RX FIFO.
module spi_byte_seq
  import spi_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [BYTE_W-1:0]           TX_DATA,
  input  logic                        TX_VALID,
  output logic                        TX_READY,
  output logic [BYTE_W-1:0]           RX_DATA,
  output logic                        RX_VALID,
  input  logic                        RX_READY,
  output logic [level_w(DEPTH)-1:0]   TX_LEVEL,
  output logic [level_w(DEPTH)-1:0]   RX_LEVEL,
  output logic                        ERR,
  input  logic                        ERR_CLR,
  output logic                        SPI_START,
  input  logic                        SPI_BUSY,
  output logic [BYTE_W-1:0]           SPI_DOUT,
  input  logic [BYTE_W-1:0]           SPI_DIN
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_push, rx_pop, rx_full, rx_empty, rx_space;

  assign tx_push  = TX_VALID && !tx_full;
  assign TX_READY = !tx_full;
  assign RX_VALID = !rx_empty;

  // A slot must be free for the byte about to be launched; a pop in this same cycle frees one.
  assign rx_pop   = RX_READY && !rx_empty;
  assign rx_space = !rx_full || rx_pop;

  assign SPI_START = (state_q == ST_LAUNCH);
  assign SPI_DOUT  = dout_q;
  assign ERR       = err_q;

  spi_fifo_m #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (tx_push),
    .push_data (TX_DATA),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (TX_LEVEL),
    .head      (tx_head)
  );

  spi_fifo_m #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (rx_push),
    .push_data (SPI_DIN),
    .pop       (RX_READY),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (RX_LEVEL),
    .head      (RX_DATA)
  );

  // Next-state for the transfer FSM, the held DOUT byte, the launch timeout and the sticky error.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;

    if (ERR_CLR) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Holding off while BUSY is high lets a transfer orphaned by reset finish first.
        if (!tx_empty && rx_space && !SPI_BUSY) begin
          tx_pop  = 1'b1;
          dout_d  = tx_head;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (SPI_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!SPI_BUSY) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register FSM state and datapath; reset abandons any byte in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_seq.sv
// Directed bench for spi_byte_seq with a small behavioural SPI master model.
module tb_spi_byte_seq;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       CLK;
  logic       RST_N;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [2:0] TX_LEVEL;
  logic [2:0] RX_LEVEL;
  logic       ERR;
  logic       ERR_CLR;
  logic       SPI_START;
  logic       SPI_BUSY;
  logic [7:0] SPI_DOUT;
  logic [7:0] SPI_DIN;

  int total = 0;
  int bad   = 0;

  // Master model controls and observations
  bit         master_en  = 1'b1;
  bit         echo_fixed = 1'b0;
  bit         busy_hold  = 1'b0;
  logic [7:0] echo_byte  = 8'h00;
  int         busy_len   = 4;
  logic       master_busy = 1'b0;
  int         launches = 0;
  int         dout_unstable = 0;
  logic [7:0] launched_q [$];

  assign SPI_BUSY = master_busy | busy_hold;

  spi_byte_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .TX_LEVEL  (TX_LEVEL),
    .RX_LEVEL  (RX_LEVEL),
    .ERR       (ERR),
    .ERR_CLR   (ERR_CLR),
    .SPI_START (SPI_START),
    .SPI_BUSY  (SPI_BUSY),
    .SPI_DOUT  (SPI_DOUT),
    .SPI_DIN   (SPI_DIN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Record every START pulse and the byte presented with it.
  initial begin
    forever begin
      @(negedge CLK);
      if (SPI_START === 1'b1) begin
        launches++;
        launched_q.push_back(SPI_DOUT);
      end
    end
  end

  // Master model: answers START with a BUSY window, watches DOUT stay put, then returns a byte.
  initial begin
    logic [7:0] cap;
    SPI_DIN = 8'h00;
    forever begin
      @(negedge CLK);
      if (SPI_START === 1'b1 && master_en) begin
        cap = SPI_DOUT;
        master_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
          @(negedge CLK);
          if (SPI_DOUT !== cap) dout_unstable++;
        end
        SPI_DIN = echo_fixed ? echo_byte : cap;
        master_busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    TX_VALID = 1'b1;
    TX_DATA  = b;
    step();
    TX_VALID = 1'b0;
  endtask

  task automatic pop_rx();
    RX_READY = 1'b1;
    step();
    RX_READY = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (SPI_START === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_rx_level(input int lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (RX_LEVEL === 3'(lvl)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    steps(2);
    RST_N = 1'b1;
    total++; if (SPI_START !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b want 0", SPI_START); end
    total++; if (SPI_DOUT !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %h want 00", SPI_DOUT); end
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", ERR); end
    step();
    total++; if (TX_READY !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_ready: got %b want 1", TX_READY); end
    total++; if (RX_VALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got %b want 0", RX_VALID); end
    total++; if (RX_DATA !== 8'h00) begin bad++; $display("[TB] FAIL reset_rx_data: got %h want 00", RX_DATA); end
    total++; if (TX_LEVEL !== 3'd0 || RX_LEVEL !== 3'd0) begin bad++; $display("[TB] FAIL reset_levels: got %0d/%0d want 0/0", TX_LEVEL, RX_LEVEL); end
  endtask

  task automatic test_single_byte();
    int n0, u0;
    bit ok;
    n0 = launches;
    u0 = dout_unstable;
    echo_fixed = 1'b1;
    echo_byte  = 8'h3C;
    push_byte(8'hA5);
    total++; if (SPI_START !== 1'b0) begin bad++; $display("[TB] FAIL single_start_early: got %b want 0", SPI_START); end
    step();
    total++; if (SPI_START !== 1'b1) begin bad++; $display("[TB] FAIL single_start_latency: got %b want 1", SPI_START); end
    total++; if (SPI_DOUT !== 8'hA5) begin bad++; $display("[TB] FAIL single_dout: got %h want a5", SPI_DOUT); end
    step();
    total++; if (SPI_START !== 1'b0) begin bad++; $display("[TB] FAIL single_start_width: got %b want 0", SPI_START); end
    wait_rx_level(1, 30, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL single_rx_arrive: got level %0d want 1", RX_LEVEL); end
    total++; if (RX_VALID !== 1'b1 || RX_DATA !== 8'h3C) begin bad++; $display("[TB] FAIL single_rx_data: got %b/%h want 1/3c", RX_VALID, RX_DATA); end
    total++; if (launches - n0 !== 1) begin bad++; $display("[TB] FAIL single_launch_count: got %0d want 1", launches - n0); end
    total++; if (dout_unstable - u0 !== 0) begin bad++; $display("[TB] FAIL single_dout_stable: got %0d changes want 0", dout_unstable - u0); end
    echo_fixed = 1'b0;
    pop_rx();
    total++; if (RX_VALID !== 1'b0 || RX_DATA !== 8'h00) begin bad++; $display("[TB] FAIL single_rx_pop: got %b/%h want 0/00", RX_VALID, RX_DATA); end
  endtask

  task automatic test_burst_fill();
    int n0;
    bit ok;
    n0 = launches;
    RX_READY  = 1'b0;
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (TX_READY !== 1'b1) begin bad++; $display("[TB] FAIL burst_ready_%0d: got %b want 1", i, TX_READY); end
      push_byte(8'(i + 1));
    end
    total++; if (TX_LEVEL !== 3'd4 || TX_READY !== 1'b0) begin bad++; $display("[TB] FAIL burst_tx_full: got %0d/%b want 4/0", TX_LEVEL, TX_READY); end
    push_byte(8'hEE);
    total++; if (TX_LEVEL !== 3'd4) begin bad++; $display("[TB] FAIL burst_push_when_full: got %0d want 4", TX_LEVEL); end
    total++; if (launches !== n0) begin bad++; $display("[TB] FAIL burst_launch_while_busy: got %0d want %0d", launches, n0); end
    busy_hold = 1'b0;
    wait_rx_level(4, 120, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL burst_rx_full: got %0d want 4", RX_LEVEL); end
    steps(10);
    total++; if (launches - n0 !== 4) begin bad++; $display("[TB] FAIL burst_launch_count: got %0d want 4", launches - n0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (launched_q[n0 + i] !== 8'(i + 1)) begin bad++; $display("[TB] FAIL burst_dout_%0d: got %h want %h", i, launched_q[n0 + i], 8'(i + 1)); end
    end
    total++; if (TX_LEVEL !== 3'd0 || RX_DATA !== 8'h01) begin bad++; $display("[TB] FAIL burst_state: got %0d/%h want 0/01", TX_LEVEL, RX_DATA); end
  endtask

  task automatic test_rx_backpressure();
    int n0;
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h03; exp[1] = 8'h04; exp[2] = 8'h55;
    n0 = launches;
    push_byte(8'h55);
    steps(8);
    total++; if (launches !== n0) begin bad++; $display("[TB] FAIL bp_no_start: got %0d want %0d", launches, n0); end
    total++; if (TX_LEVEL !== 3'd1 || RX_LEVEL !== 3'd4) begin bad++; $display("[TB] FAIL bp_levels: got %0d/%0d want 1/4", TX_LEVEL, RX_LEVEL); end
    RX_READY = 1'b1;
    total++; if (RX_DATA !== 8'h01) begin bad++; $display("[TB] FAIL bp_pop_head: got %h want 01", RX_DATA); end
    step();
    RX_READY = 1'b0;
    total++; if (SPI_START !== 1'b1 || SPI_DOUT !== 8'h55) begin bad++; $display("[TB] FAIL bp_launch_with_pop: got %b/%h want 1/55", SPI_START, SPI_DOUT); end
    total++; if (RX_LEVEL !== 3'd3) begin bad++; $display("[TB] FAIL bp_level_after_pop: got %0d want 3", RX_LEVEL); end
    wait_rx_level(4, 40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL bp_refill: got %0d want 4", RX_LEVEL); end
    steps(10);
    total++; if (launches - n0 !== 1) begin bad++; $display("[TB] FAIL bp_launch_count: got %0d want 1", launches - n0); end
    pop_rx();
    steps(10);
    total++; if (launches - n0 !== 1 || RX_LEVEL !== 3'd3) begin bad++; $display("[TB] FAIL bp_tx_empty_idle: got %0d/%0d want 1/3", launches - n0, RX_LEVEL); end
    for (int i = 0; i < 3; i++) begin
      total++; if (RX_VALID !== 1'b1 || RX_DATA !== exp[i]) begin bad++; $display("[TB] FAIL bp_drain_%0d: got %b/%h want 1/%h", i, RX_VALID, RX_DATA, exp[i]); end
      pop_rx();
    end
    total++; if (RX_LEVEL !== 3'd0) begin bad++; $display("[TB] FAIL bp_drained: got %0d want 0", RX_LEVEL); end
  endtask

  task automatic test_timeout();
    bit seen, ok;
    master_en = 1'b0;
    push_byte(8'h77);
    wait_start(10, seen);
    total++; if (!seen || SPI_DOUT !== 8'h77) begin bad++; $display("[TB] FAIL to_launch: got %b/%h want 1/77", seen, SPI_DOUT); end
    steps(TIMEOUT);
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL to_err_early: got %b want 0", ERR); end
    step();
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL to_err_set: got %b want 1", ERR); end
    total++; if (RX_LEVEL !== 3'd0) begin bad++; $display("[TB] FAIL to_rx_level: got %0d want 0", RX_LEVEL); end
    master_en = 1'b1;
    push_byte(8'h88);
    wait_start(10, seen);
    total++; if (!seen || SPI_DOUT !== 8'h88) begin bad++; $display("[TB] FAIL to_relaunch: got %b/%h want 1/88", seen, SPI_DOUT); end
    wait_rx_level(1, 30, ok);
    total++; if (!ok || RX_DATA !== 8'h88) begin bad++; $display("[TB] FAIL to_relaunch_rx: got %0d/%h want 1/88", RX_LEVEL, RX_DATA); end
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL to_err_sticky: got %b want 1", ERR); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL to_err_clr: got %b want 0", ERR); end
    pop_rx();
    master_en = 1'b0;
    push_byte(8'h66);
    wait_start(10, seen);
    total++; if (!seen) begin bad++; $display("[TB] FAIL to_launch2: got %b want 1", seen); end
    steps(TIMEOUT);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL to_clr_vs_timeout: got %b want 1", ERR); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL to_err_clr2: got %b want 0", ERR); end
    master_en = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    int n0;
    bit seen, ok, early;
    busy_len = 12;
    push_byte(8'h99);
    wait_start(10, seen);
    steps(3);
    push_byte(8'hAB);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    total++; if (TX_LEVEL !== 3'd0 || RX_LEVEL !== 3'd0) begin bad++; $display("[TB] FAIL rst_levels: got %0d/%0d want 0/0", TX_LEVEL, RX_LEVEL); end
    total++; if (TX_READY !== 1'b1 || RX_VALID !== 1'b0) begin bad++; $display("[TB] FAIL rst_handshake: got %b/%b want 1/0", TX_READY, RX_VALID); end
    total++; if (SPI_START !== 1'b0 || SPI_DOUT !== 8'h00) begin bad++; $display("[TB] FAIL rst_spi: got %b/%h want 0/00", SPI_START, SPI_DOUT); end
    n0 = launches;
    busy_len = 4;
    push_byte(8'h12);
    early = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (SPI_BUSY !== 1'b1) break;
      if (SPI_START === 1'b1) early = 1'b1;
      step();
    end
    total++; if (early || launches !== n0) begin bad++; $display("[TB] FAIL rst_launch_while_busy: got %0d launches want 0", launches - n0); end
    wait_start(10, seen);
    total++; if (!seen || SPI_DOUT !== 8'h12) begin bad++; $display("[TB] FAIL rst_new_launch: got %b/%h want 1/12", seen, SPI_DOUT); end
    wait_rx_level(1, 30, ok);
    total++; if (!ok || RX_DATA !== 8'h12) begin bad++; $display("[TB] FAIL rst_new_rx: got %0d/%h want 1/12", RX_LEVEL, RX_DATA); end
    steps(5);
    total++; if (RX_LEVEL !== 3'd1) begin bad++; $display("[TB] FAIL rst_stale_dropped: got %0d want 1", RX_LEVEL); end
    pop_rx();
  endtask

  task automatic test_rx_full_push_pop();
    int n0;
    bit ok;
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h12; exp[2] = 8'h13; exp[3] = 8'h14;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    wait_rx_level(4, 120, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL full_fill: got %0d want 4", RX_LEVEL); end
    n0 = launches;
    push_byte(8'h14);
    steps(5);
    total++; if (launches !== n0 || TX_LEVEL !== 3'd1) begin bad++; $display("[TB] FAIL full_hold: got %0d/%0d want 0/1", launches - n0, TX_LEVEL); end
    RX_READY = 1'b1;
    total++; if (RX_DATA !== 8'h10) begin bad++; $display("[TB] FAIL full_head: got %h want 10", RX_DATA); end
    step();
    RX_READY = 1'b0;
    total++; if (SPI_START !== 1'b1 || SPI_DOUT !== 8'h14 || RX_LEVEL !== 3'd3) begin bad++; $display("[TB] FAIL full_pop_launch: got %b/%h/%0d want 1/14/3", SPI_START, SPI_DOUT, RX_LEVEL); end
    wait_rx_level(4, 40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL full_refill: got %0d want 4", RX_LEVEL); end
    for (int i = 0; i < 4; i++) begin
      total++; if (RX_VALID !== 1'b1 || RX_DATA !== exp[i]) begin bad++; $display("[TB] FAIL full_order_%0d: got %b/%h want 1/%h", i, RX_VALID, RX_DATA, exp[i]); end
      pop_rx();
    end
    total++; if (RX_LEVEL !== 3'd0 || RX_VALID !== 1'b0) begin bad++; $display("[TB] FAIL full_drained: got %0d/%b want 0/0", RX_LEVEL, RX_VALID); end
  endtask

  initial begin
    RST_N    = 1'b0;
    TX_DATA  = 8'h00;
    TX_VALID = 1'b0;
    RX_READY = 1'b0;
    ERR_CLR  = 1'b0;
    $display("[TB] starting spi_byte_seq bench");
    test_reset();
    test_single_byte();
    test_burst_fill();
    test_rx_backpressure();
    test_timeout();
    test_reset_mid_transfer();
    test_rx_full_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
